ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable)
//  to the keyboard over the shared open-drain PS2_CLK/PS2_DATA pair. Performs clock inhibit,

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_line_sync.sv | 30 +++
 rtl/ps2_host_tx.sv | 171 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared state encoding, command constants and parity helper for the PS/2 host-side blocks.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE,
    DONE
  } ps2_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one raw PS/2 line plus a one-cycle falling-edge pulse.
module ps2_line_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Reset to the idle (released-high) bus level so no false fall appears after reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, frames one byte, checks the device ACK.
//
//   state     | meaning
//   IDLE      | bus released, ready for a byte
//   INHIBIT   | PS2_CLK held low for INHIBIT_CYCLES
//   START     | start bit (data low), clock released, waiting for first device fall
//   DATA      | data bits 0..7 presented after falls 1..8
//   PARITY    | parity presented after fall 9
//   STOP      | data released as stop bit; ACK sampled on fall 11
//   WAIT_IDLE | waiting for both lines high
//   DONE      | one-cycle completion pulse
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ack_ok,
  output logic       o_err_timeout,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_ps2_clk_drive_low,
  output logic       o_ps2_data_drive_low
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t       r_state;
  logic [7:0]       r_shift;
  logic             r_parity;
  logic [2:0]       r_bit_idx;
  logic [INH_W-1:0] r_inh_cnt;
  logic [TMO_W-1:0] r_tmo_cnt;

  logic w_clk_sync;
  logic w_clk_fall;
  logic w_data_sync;
  logic w_data_fall_unused;
  logic w_in_frame;
  logic w_tmo_hit;

  ps2_line_sync u_clk_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_line  (i_ps2_clk),
    .o_sync  (w_clk_sync),
    .o_fall  (w_clk_fall)
  );

  ps2_line_sync u_data_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_line  (i_ps2_data),
    .o_sync  (w_data_sync),
    .o_fall  (w_data_fall_unused)
  );

  assign w_in_frame = (r_state == START) || (r_state == DATA) || (r_state == PARITY) ||
                      (r_state == STOP)  || (r_state == WAIT_IDLE);
  assign w_tmo_hit  = w_in_frame && (r_tmo_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state              <= IDLE;
      o_tx_ready           <= 1'b1;
      o_busy               <= 1'b0;
      o_done               <= 1'b0;
      o_ack_ok             <= 1'b0;
      o_err_timeout        <= 1'b0;
      o_ps2_clk_drive_low  <= 1'b0;
      o_ps2_data_drive_low <= 1'b0;
      r_shift              <= '0;
      r_parity             <= 1'b0;
      r_bit_idx            <= '0;
      r_inh_cnt            <= '0;
      r_tmo_cnt            <= '0;
    end else begin
      o_done <= 1'b0;
      // Timeout wins over any fall seen in the same cycle.
      if (w_tmo_hit) begin
        r_state              <= DONE;
        o_done               <= 1'b1;
        o_ack_ok             <= 1'b0;
        o_err_timeout        <= 1'b1;
        o_ps2_clk_drive_low  <= 1'b0;
        o_ps2_data_drive_low <= 1'b0;
      end else begin
        if (w_in_frame) r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
        case (r_state)
          IDLE: begin
            if (i_tx_valid && o_tx_ready) begin
              r_state             <= INHIBIT;
              o_tx_ready          <= 1'b0;
              o_busy              <= 1'b1;
              o_ack_ok            <= 1'b0;
              o_err_timeout       <= 1'b0;
              o_ps2_clk_drive_low <= 1'b1;
              r_shift             <= i_tx_data;
              r_parity            <= odd_parity(i_tx_data);
              r_inh_cnt           <= INH_LOAD;
            end
          end
          INHIBIT: begin
            if (r_inh_cnt == '0) begin
              r_state              <= START;
              o_ps2_clk_drive_low  <= 1'b0;
              o_ps2_data_drive_low <= 1'b1;
              r_tmo_cnt            <= TMO_LOAD;
              r_bit_idx            <= '0;
            end else begin
              r_inh_cnt <= r_inh_cnt - INH_W'(1);
            end
          end
          START: begin
            if (w_clk_fall) begin
              r_state              <= DATA;
              o_ps2_data_drive_low <= ~r_shift[0];
            end
          end
          DATA: begin
            if (w_clk_fall) begin
              if (r_bit_idx == 3'd7) begin
                r_state              <= PARITY;
                o_ps2_data_drive_low <= ~r_parity;
              end else begin
                r_shift              <= {1'b0, r_shift[7:1]};
                o_ps2_data_drive_low <= ~r_shift[1];
                r_bit_idx            <= r_bit_idx + 3'd1;
              end
            end
          end
          PARITY: begin
            if (w_clk_fall) begin
              r_state              <= STOP;
              o_ps2_data_drive_low <= 1'b0;
            end
          end
          STOP: begin
            if (w_clk_fall) begin
              r_state  <= WAIT_IDLE;
              o_ack_ok <= ~w_data_sync;
            end
          end
          WAIT_IDLE: begin
            if (w_clk_sync && w_data_sync) begin
              r_state <= DONE;
              o_done  <= 1'b1;
            end
          end
          DONE: begin
            r_state    <= IDLE;
            o_tx_ready <= 1'b1;
            o_busy     <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on a wired-AND bus.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 20;
  localparam int TMO = 1500;
  localparam int HP  = 15;

  typedef struct {
    logic [7:0] data;
    bit         clocks;
    bit         ack;
    bit         exp_par;
    bit         exp_ack;
    bit         exp_tmo;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, done, ack_ok, err_timeout;
  logic       clk_low, data_low;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  wire        ps2_clk  = dev_clk & ~clk_low;
  wire        ps2_data = dev_data & ~data_low;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[6];

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_tx_valid           (tx_valid),
    .i_tx_data            (tx_data),
    .o_tx_ready           (tx_ready),
    .o_busy               (busy),
    .o_done               (done),
    .o_ack_ok             (ack_ok),
    .o_err_timeout        (err_timeout),
    .i_ps2_clk            (ps2_clk),
    .i_ps2_data           (ps2_data),
    .o_ps2_clk_drive_low  (clk_low),
    .o_ps2_data_drive_low (data_low)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Device clocks n_falls pulses, samples the bus just before each rise, ACKs after rise 10.
  task automatic device_clock(input int n_falls, input bit ack, output logic [9:0] bits);
    bits = '0;
    repeat (HP) @(negedge clk);
    for (int i = 1; i <= n_falls; i++) begin
      dev_clk = 1'b0;
      repeat (HP) @(negedge clk);
      if (i <= 10) bits[i-1] = ps2_data;
      dev_clk = 1'b1;
      if (i == 10 && ack) dev_data = 1'b0;
      if (i == 11) begin
        dev_data = 1'b1;
        break;
      end
      repeat (HP) @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    @(negedge clk);
  endtask

  // Entered at the first negedge after acceptance; returns at the negedge after DONE.
  task automatic finish_frame(input vec_t v);
    int         cnt;
    bit         data_ok;
    logic [9:0] bits;
    chk("busy_on_accept", 32'(busy), 32'd1);
    chk("ready_on_accept", 32'(tx_ready), 32'd0);
    cnt = 0;
    data_ok = 1'b1;
    while (clk_low && cnt < 1000) begin
      if (data_low) data_ok = 1'b0;
      cnt++;
      @(negedge clk);
    end
    chk("inhibit_len", 32'(cnt), 32'(INH));
    chk("inhibit_data_released", 32'(data_ok), 32'd1);
    chk("start_bit", 32'(data_low), 32'd1);
    if (v.clocks) begin
      device_clock(11, v.ack, bits);
      chk("data_bits", 32'(bits[7:0]), 32'(v.data));
      chk("parity_bit", 32'(bits[8]), 32'(v.exp_par));
      chk("stop_bit", 32'(bits[9]), 32'd1);
      cnt = 0;
      while (!done && cnt < 200) begin
        @(negedge clk);
        cnt++;
      end
      chk("done_seen", 32'(done), 32'd1);
    end else begin
      cnt = 0;
      while (!done && cnt < 5000) begin
        @(negedge clk);
        cnt++;
      end
      chk("timeout_len", 32'(cnt), 32'(TMO));
    end
    chk("ack_ok", 32'(ack_ok), 32'(v.exp_ack));
    chk("err_timeout", 32'(err_timeout), 32'(v.exp_tmo));
    chk("clk_released", 32'(clk_low), 32'd0);
    chk("data_released", 32'(data_low), 32'd0);
    chk("busy_in_done", 32'(busy), 32'd1);
    @(negedge clk);
    chk("done_pulse_1cyc", 32'(done), 32'd0);
    chk("ready_after_done", 32'(tx_ready), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("ack_held", 32'(ack_ok), 32'(v.exp_ack));
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [9:0] bits;

    vecs[0] = '{data: CMD_SET_LEDS, clocks: 1, ack: 1, exp_par: 1, exp_ack: 1, exp_tmo: 0};
    vecs[1] = '{data: 8'h00,        clocks: 1, ack: 1, exp_par: 1, exp_ack: 1, exp_tmo: 0};
    vecs[2] = '{data: 8'h01,        clocks: 1, ack: 1, exp_par: 0, exp_ack: 1, exp_tmo: 0};
    vecs[3] = '{data: CMD_ENABLE,   clocks: 1, ack: 0, exp_par: 0, exp_ack: 0, exp_tmo: 0};
    vecs[4] = '{data: CMD_RESET,    clocks: 0, ack: 0, exp_par: 1, exp_ack: 0, exp_tmo: 1};
    vecs[5] = '{data: 8'hA5,        clocks: 1, ack: 1, exp_par: 1, exp_ack: 1, exp_tmo: 0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ack", 32'(ack_ok), 32'd0);
    chk("rst_tmo", 32'(err_timeout), 32'd0);
    chk("rst_clk_low", 32'(clk_low), 32'd0);
    chk("rst_data_low", 32'(data_low), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].data);
      finish_frame(vecs[i]);
      repeat (5) @(negedge clk);
    end

    // Reset while bit 4 of 0xA5 (a 0) is on the bus.
    send(8'hA5);
    while (clk_low) @(negedge clk);
    device_clock(5, 1'b0, bits);
    chk("mid_frame_bit4", 32'(data_low), 32'd1);
    chk("mid_frame_bits", 32'(bits[3:0]), 32'h5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_clk_low", 32'(clk_low), 32'd0);
    chk("midrst_data_low", 32'(data_low), 32'd0);
    chk("midrst_ready", 32'(tx_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send(CMD_SET_LEDS);
    finish_frame(vecs[0]);
    repeat (5) @(negedge clk);

    // tx_valid held through a frame with changed data: only the first byte goes out.
    tx_valid = 1'b1;
    tx_data  = CMD_SET_LEDS;
    @(negedge clk);
    tx_data = CMD_RESET;
    finish_frame(vecs[0]);
    @(negedge clk);
    chk("second_accept_busy", 32'(busy), 32'd1);
    chk("second_accept_clk_low", 32'(clk_low), 32'd1);
    tx_valid = 1'b0;
    v = '{data: CMD_RESET, clocks: 1, ack: 1, exp_par: 1, exp_ack: 1, exp_tmo: 0};
    finish_frame(v);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
